// File: rtl/m_uart_pkg.sv
// Shared character constants and FSM state types for the UART buffer controller.
package m_uart_pkg;

  localparam logic [7:0] CHAR_CR  = 8'h0d;
  localparam logic [7:0] CHAR_LF  = 8'h0a;
  localparam logic [7:0] CHAR_NUL = 8'h00;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_FETCH = 2'd1,
    T_SEND  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LF   = 2'd1,
    W_NUL  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/m_line_writer.sv
// RX line writer: stores received bytes at RX_BASE, terminates a line on CR with LF+NUL,
// and flags a completed line so the top level can echo it.
module m_line_writer
  import m_uart_pkg::*;
#(
  parameter logic [9:0] RX_BASE  = 10'h100,
  parameter int         LINE_MAX = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       we,
  output logic [9:0] waddr,
  output logic [7:0] wdata,
  output logic       ovf,
  output logic       line_done
);

  // Three slots are always kept free so CR, LF and NUL fit after the payload.
  localparam logic [9:0] WLIMIT = RX_BASE + 10'(LINE_MAX - 3);

  wr_state_t  state;
  logic [9:0] wptr;
  logic       accept;
  logic       is_cr;
  logic       room;

  assign rx_ready = !rst && (state == W_IDLE) && !hold;
  assign accept   = rx_ready && rx_valid;
  assign is_cr    = (rx_data == CHAR_CR);
  assign room     = (wptr < WLIMIT);

  always_comb begin
    we        = 1'b0;
    waddr     = 10'd0;
    wdata     = 8'd0;
    line_done = 1'b0;
    if (!rst) begin
      case (state)
        W_IDLE: begin
          if (accept && (is_cr || room)) begin
            we    = 1'b1;
            waddr = wptr;
            wdata = rx_data;
          end
        end
        W_LF: begin
          we    = 1'b1;
          waddr = wptr;
          wdata = CHAR_LF;
        end
        W_NUL: begin
          we        = 1'b1;
          waddr     = wptr;
          wdata     = CHAR_NUL;
          line_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= W_IDLE;
      wptr  <= RX_BASE;
      ovf   <= 1'b0;
    end else begin
      case (state)
        W_IDLE: begin
          if (accept) begin
            if (is_cr) begin
              wptr  <= wptr + 10'd1;
              ovf   <= 1'b0;
              state <= W_LF;
            end else if (room) begin
              wptr <= wptr + 10'd1;
            end else begin
              ovf <= 1'b1;
            end
          end
        end
        W_LF: begin
          wptr  <= wptr + 10'd1;
          state <= W_NUL;
        end
        W_NUL: begin
          wptr  <= RX_BASE;
          state <= W_IDLE;
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/m_uart_buf_ctrl.sv
// UART buffer sequencer: streams NUL-terminated strings from memory to UART TX and
// echoes completed RX lines; arbitrates the START string against pending echoes.
module m_uart_buf_ctrl
  import m_uart_pkg::*;
#(
  parameter logic [9:0] TX_BASE  = 10'h000,
  parameter logic [9:0] RX_BASE  = 10'h100,
  parameter int         LINE_MAX = 128,
  parameter int         MAX_LEN  = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVF,
  output logic       TX_VALID,
  input  logic       TX_READY,
  output logic [7:0] TX_DATA,
  input  logic       RX_VALID,
  output logic       RX_READY,
  input  logic [7:0] RX_DATA,
  output logic [9:0] MEM_RADDR,
  input  logic [7:0] MEM_RDATA,
  output logic       MEM_WE,
  output logic [9:0] MEM_WADDR,
  output logic [7:0] MEM_WDATA
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  tx_state_t        tx_state;
  logic [9:0]       rptr;
  logic [CNT_W-1:0] cnt;
  logic             echo_req;
  logic             echo_active;
  logic             line_done;

  assign MEM_RADDR = rptr;

  // RX is held off while an echo is pending or in flight so the line is not overwritten.
  m_line_writer #(
    .RX_BASE  (RX_BASE),
    .LINE_MAX (LINE_MAX)
  ) u_writer (
    .clk       (CLK),
    .rst       (RST),
    .hold      (echo_req || echo_active),
    .rx_valid  (RX_VALID),
    .rx_data   (RX_DATA),
    .rx_ready  (RX_READY),
    .we        (MEM_WE),
    .waddr     (MEM_WADDR),
    .wdata     (MEM_WDATA),
    .ovf       (OVF),
    .line_done (line_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state    <= T_IDLE;
      rptr        <= TX_BASE;
      cnt         <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      TX_VALID    <= 1'b0;
      TX_DATA     <= 8'd0;
      echo_req    <= 1'b0;
      echo_active <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (tx_state)
        T_IDLE: begin
          // A pending echo wins over a simultaneous START; that START is dropped.
          if (echo_req) begin
            rptr        <= RX_BASE;
            cnt         <= '0;
            echo_req    <= 1'b0;
            echo_active <= 1'b1;
            BUSY        <= 1'b1;
            tx_state    <= T_FETCH;
          end else if (START) begin
            rptr     <= TX_BASE;
            cnt      <= '0;
            BUSY     <= 1'b1;
            tx_state <= T_FETCH;
          end
        end
        T_FETCH: begin
          if (MEM_RDATA == CHAR_NUL || cnt == CNT_W'(MAX_LEN)) begin
            DONE        <= 1'b1;
            BUSY        <= 1'b0;
            echo_active <= 1'b0;
            tx_state    <= T_IDLE;
          end else begin
            TX_DATA  <= MEM_RDATA;
            TX_VALID <= 1'b1;
            tx_state <= T_SEND;
          end
        end
        T_SEND: begin
          if (TX_READY) begin
            TX_VALID <= 1'b0;
            rptr     <= rptr + 10'd1;
            cnt      <= cnt + CNT_W'(1);
            tx_state <= T_FETCH;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
      if (line_done) echo_req <= 1'b1;
    end
  end

endmodule
